tdc_sample_accum: RTL and testbench

TDC_SAMPLE_ACCUM -- requirements
Module: tdc_sample_accum

---
 rtl/tdc_sample_accum.sv | 167 ++++++++++++++++
 tb/tb_tdc_sample_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_sample_accum.sv
// tdc_sample_accum
// Accumulates a window of 2**LOG2_SAMPLES TDC hamming-weight samples. It
// produces the exact sum, the sample count and a sticky over-range flag.
// A registered byte-wide readout port exposes the results.
// Define TDC_ACCUM_MINMAX_EN to also track the minimum and maximum sample.
// Without it, readout selects 4 and 5 return zero.
module tdc_sample_accum #(
  parameter  int N            = 64,
  parameter  int LOG2_SAMPLES = 8,
  localparam int HW_W         = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hw_valid,
  input  logic [HW_W-1:0] hw_in,
  input  logic [2:0]      rd_sel,
  output logic [7:0]      rd_data,
  output logic            busy,
  output logic            done
);

  localparam int SUM_W = HW_W + LOG2_SAMPLES;
  localparam logic [HW_W-1:0] N_HW = HW_W'(N);

  if (SUM_W > 32) begin : g_sum_width_check
    $error("tdc_sample_accum: HW_W + LOG2_SAMPLES must not exceed 32");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q;
  logic                    busy_q, done_q;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [LOG2_SAMPLES-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              rd_q, rd_d;

  logic                    accept;
  logic                    overRange;
  logic [HW_W-1:0]         sample;
  logic [31:0]             sum32;

  // A sample is only taken inside a window, and start always wins the cycle.
  assign accept    = (state_q == ACCUM) && hw_valid && !start;
  assign overRange = hw_in > N_HW;
  assign sample    = overRange ? N_HW : hw_in;
  assign sum32     = 32'(sum_q);

`ifdef TDC_ACCUM_MINMAX_EN
  logic [HW_W-1:0] min_q, min_d;
  logic [HW_W-1:0] max_q, max_d;

  // Min/max next-state: reset to the empty-window values on start.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (start) begin
      min_d = N_HW;
      max_d = '0;
    end else if (accept) begin
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
    end
  end

  // Min/max registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= N_HW;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
`endif

  // Window control: the last sample of a window moves the FSM into DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= ACCUM;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept && (count_q == '1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
          busy_q  <= busy_q;
          done_q  <= done_q;
        end
      endcase
    end
  end

  // Accumulator next-state; the count wraps to zero as the window fills.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (start) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      sum_d   = sum_q + SUM_W'(sample);
      count_d = count_q + 1'b1;
      ovf_d   = ovf_q | overRange;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Readout mux; it shows live values, so a read during a window sees partial results.
  always_comb begin
    rd_d = 8'h00;
    case (rd_sel)
      3'd0: rd_d = sum32[7:0];
      3'd1: rd_d = sum32[15:8];
      3'd2: rd_d = sum32[23:16];
      3'd3: rd_d = sum32[31:24];
`ifdef TDC_ACCUM_MINMAX_EN
      3'd4: rd_d = 8'(min_q);
      3'd5: rd_d = 8'(max_q);
`else
      3'd4: rd_d = 8'h00;
      3'd5: rd_d = 8'h00;
`endif
      3'd6: rd_d = 8'(count_q);
      3'd7: rd_d = {5'b0, ovf_q, done_q, busy_q};
      default: rd_d = 8'h00;
    endcase
  end

  // Readout register.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 8'h00;
    else        rd_q <= rd_d;
  end

  assign rd_data = rd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tdc_sample_accum.sv
// tb_tdc_sample_accum
// Directed and randomized checks of tdc_sample_accum with N=64 and a
// four-sample window. The reference model keeps each accepted window as a
// queue of clamped samples and derives sum/min/max/count from that queue.
module tb_tdc_sample_accum;

  localparam int N    = 64;
  localparam int LOG2 = 2;
  localparam int WIN  = 1 << LOG2;
  localparam int HW_W = $clog2(N) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hw_valid = 1'b0;
  logic [HW_W-1:0] hw_in = '0;
  logic [2:0]      rd_sel = '0;
  logic [7:0]      rd_data;
  logic            busy;
  logic            done;

  int vectors = 0;
  int miscompares = 0;

  int   win[$];
  bit   mOvf = 1'b0;
  bit   mBusy = 1'b0;
  bit   mDone = 1'b0;
  logic [7:0] rdExp = 8'h00;

  tdc_sample_accum #(.N(N), .LOG2_SAMPLES(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hw_valid(hw_valid),
    .hw_in(hw_in), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] readout(input int sel);
    int s = 0;
    int mn = N;
    int mx = 0;
    logic [31:0] s32;
    foreach (win[i]) begin
      s += win[i];
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
    end
    s32 = 32'(s);
    case (sel)
      0: return s32[7:0];
      1: return s32[15:8];
      2: return s32[23:16];
      3: return s32[31:24];
`ifdef TDC_ACCUM_MINMAX_EN
      4: return 8'(mn);
      5: return 8'(mx);
`else
      4: return 8'h00;
      5: return 8'h00;
`endif
      6: return 8'(win.size() % WIN);
      default: return {5'b0, mOvf, mDone, mBusy};
    endcase
  endfunction

  task automatic modelEdge(input bit rn, input bit st, input bit v, input int hw, input int sel);
    if (!rn) begin
      win.delete();
      mOvf  = 1'b0;
      mBusy = 1'b0;
      mDone = 1'b0;
      rdExp = 8'h00;
    end else begin
      rdExp = readout(sel);
      if (st) begin
        win.delete();
        mOvf  = 1'b0;
        mBusy = 1'b1;
        mDone = 1'b0;
      end else if (mBusy && v) begin
        win.push_back(hw > N ? N : hw);
        if (hw > N) mOvf = 1'b1;
        if (win.size() == WIN) begin
          mBusy = 1'b0;
          mDone = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (busy === mBusy) else begin
      miscompares++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, mBusy);
    end
    vectors++;
    assert (done === mDone) else begin
      miscompares++;
      $error("FAIL %s done observed=%b expected=%b", tag, done, mDone);
    end
    vectors++;
    assert (rd_data === rdExp) else begin
      miscompares++;
      $error("FAIL %s rd_data observed=%h expected=%h", tag, rd_data, rdExp);
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit st, input bit v, input int hw,
                               input int sel, input string tag);
    @(negedge clk);
    rst_n    = rn;
    start    = st;
    hw_valid = v;
    hw_in    = HW_W'(hw);
    rd_sel   = 3'(sel);
    @(posedge clk);
    modelEdge(rn, st, v, hw, sel);
    #1;
    checkOutput(tag);
  endtask

  task automatic readAll(input string tag);
    for (int s = 0; s < 8; s++) applyStimulus(1, 0, 0, 0, s, tag);
    applyStimulus(1, 0, 0, 0, 7, tag);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int smp[4];

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 7, "reset");
    applyStimulus(0, 1, 1, 5, 7, "reset_over_start");
    applyStimulus(1, 0, 0, 0, 7, "status_after_reset");
    applyStimulus(1, 0, 0, 0, 4, "min_after_reset");
    applyStimulus(1, 0, 0, 0, 4, "min_after_reset2");

    $display("[TB] basic window");
    smp = '{10, 20, 30, 40};
    applyStimulus(1, 1, 0, 0, 0, "w1_start");
    foreach (smp[i]) applyStimulus(1, 0, 1, smp[i], 6, "w1_sample");
    applyStimulus(1, 0, 1, 50, 7, "w1_ignored_in_done");
    readAll("w1_read");

    $display("[TB] clamp and overflow");
    smp = '{5, 70, 0, 64};
    applyStimulus(1, 1, 0, 0, 7, "w2_start");
    foreach (smp[i]) applyStimulus(1, 0, 1, smp[i], 0, "w2_sample");
    readAll("w2_read");

    $display("[TB] restart mid-window");
    applyStimulus(1, 1, 0, 0, 6, "w3_start");
    applyStimulus(1, 0, 1, 3, 6, "w3_s1");
    applyStimulus(1, 0, 1, 4, 0, "w3_s2");
    applyStimulus(1, 1, 1, 9, 0, "w3_restart");
    applyStimulus(1, 0, 0, 0, 6, "w3_count_zero");
    applyStimulus(1, 0, 1, 11, 0, "w3_n1");
    applyStimulus(1, 0, 1, 12, 0, "w3_n2");
    applyStimulus(1, 0, 1, 13, 0, "w3_n3");
    applyStimulus(1, 0, 1, 14, 0, "w3_n4");
    readAll("w3_read");

    $display("[TB] reset mid-window");
    applyStimulus(1, 1, 0, 0, 0, "w4_start");
    applyStimulus(1, 0, 1, 33, 0, "w4_s1");
    applyStimulus(1, 0, 1, 44, 0, "w4_s2");
    applyStimulus(0, 0, 1, 55, 0, "w4_reset");
    applyStimulus(1, 0, 1, 20, 6, "w4_ignored1");
    applyStimulus(1, 0, 1, 21, 0, "w4_ignored2");
    readAll("w4_read");

    $display("[TB] random");
    for (int k = 0; k < 400; k++) begin
      bit rn, st, v;
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 3) != 0);
      applyStimulus(rn, st, v, $urandom_range(0, 127), $urandom_range(0, 7), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
